tetris_spi_seq: RTL

Two-port SPI transaction sequencer for the 8-bit SPI master (Avalon register port, addresses 0–6). It drives the master's register port directly and arbitrates round-robin between two requesters, e.g. the display driver and the input/sensor poller. For each granted transaction it programs slave-select, holds SS_n low through SSO, and streams bytes one at a time, returning every received byte. It reports completion or a timeout per requester.

---
 rtl/tetris_spi_pkg.sv | 41 ++++
 rtl/tetris_spi_rr_arb.sv | 30 +++
 rtl/tetris_spi_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_spi_pkg.sv
// Shared definitions for the two-port SPI transaction sequencer:
// SPI master register map, control constants, FSM states and the access descriptor.
package tetris_spi_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;

    localparam logic [ADDR_W-1:0] RXDATA  = 3'd0;
    localparam logic [ADDR_W-1:0] TXDATA  = 3'd1;
    localparam logic [ADDR_W-1:0] STATUS  = 3'd2;
    localparam logic [ADDR_W-1:0] CONTROL = 3'd3;
    localparam logic [ADDR_W-1:0] SSEL    = 3'd5;
    localparam logic [ADDR_W-1:0] EOPVAL  = 3'd6;

    localparam logic [DATA_W-1:0] CTRL_SSO = 16'h0400;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR_STAT,
        ST_SET_SSEL,
        ST_SSO_ON,
        ST_LOAD,
        ST_WR_DATA,
        ST_WAIT_RX,
        ST_RD_DATA,
        ST_SSO_OFF
    } state_t;

    // One register-port access: address plus write data.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } acc_t;

    // Registers the sequencer writes; everything else it touches is read.
    function automatic logic reg_writable(input logic [ADDR_W-1:0] addr);
        return addr inside {TXDATA, STATUS, CONTROL, SSEL, EOPVAL};
    endfunction

endpackage

// File: rtl/tetris_spi_rr_arb.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer updated on accept.
module tetris_spi_rr_arb
    import tetris_spi_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant_c
);

    // prio_q=1 favours requester 1 on a tie; reset favours requester 0.
    logic prio_q;

    always_comb begin
        grant_c = req;
        if (req == 2'b11) begin
            grant_c = prio_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= 1'b0;
        end else if (update && (grant_c != 2'b00)) begin
            prio_q <= grant_c[0];
        end
    end

endmodule

// File: rtl/tetris_spi_seq.sv
// Two-port SPI transaction sequencer driving the 8-bit SPI master register port:
// arbitrates requesters, programs slave select/SSO and streams bytes one at a time.
module tetris_spi_seq
    import tetris_spi_pkg::*;
#(
    parameter int unsigned NSLAVE      = 1,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            req_valid,
    input  logic [2*NSLAVE-1:0]   req_ssel,
    output logic [1:0]            req_grant,
    input  logic [1:0]            tx_valid,
    input  logic [15:0]           tx_data,
    input  logic [1:0]            tx_last,
    output logic [1:0]            tx_ready,
    output logic [1:0]            rx_valid,
    output logic [7:0]            rx_data,
    output logic [1:0]            done,
    output logic [1:0]            err,
    output logic                  busy,
    output logic                  spi_select,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  write_n,
    output logic                  read_n,
    output logic [DATA_W-1:0]     data_from_cpu,
    input  logic [DATA_W-1:0]     data_to_cpu,
    input  logic                  dataavailable,
    input  logic                  readyfordata
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned PH_W  = 2;

    state_t              state_q, state_n;
    logic [PH_W-1:0]     phase_q, phase_n;
    logic                owner_q, owner_n;
    logic [NSLAVE-1:0]   ssel_q, ssel_n;
    logic [BYTE_W-1:0]   byte_q, byte_n;
    logic                last_q, last_n;
    logic                have_q, have_n;
    logic                abort_q, abort_n;
    logic [TMO_W-1:0]    tmo_q, tmo_n;

    logic [1:0]          grant_c;
    logic                arb_update;
    acc_t                acc;
    logic                acc_en;
    logic                acc_end;

    logic [1:0]          req_grant_n, tx_ready_n, rx_valid_n, done_n, err_n;
    logic [7:0]          rx_data_n;
    logic                busy_n;
    logic                spi_select_n, write_n_n, read_n_n;
    logic [ADDR_W-1:0]   mem_addr_n;
    logic [DATA_W-1:0]   data_from_cpu_n;

    logic [7:0]          rd_hi_unused;
    assign rd_hi_unused = data_to_cpu[15:8];

    tetris_spi_rr_arb u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_valid),
        .update  (arb_update),
        .grant_c (grant_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            phase_q       <= '0;
            owner_q       <= 1'b0;
            ssel_q        <= '0;
            byte_q        <= '0;
            last_q        <= 1'b0;
            have_q        <= 1'b0;
            abort_q       <= 1'b0;
            tmo_q         <= '0;
            req_grant     <= '0;
            tx_ready      <= '0;
            rx_valid      <= '0;
            rx_data       <= '0;
            done          <= '0;
            err           <= '0;
            busy          <= 1'b0;
            spi_select    <= 1'b0;
            mem_addr      <= '0;
            write_n       <= 1'b1;
            read_n        <= 1'b1;
            data_from_cpu <= '0;
        end else begin
            state_q       <= state_n;
            phase_q       <= phase_n;
            owner_q       <= owner_n;
            ssel_q        <= ssel_n;
            byte_q        <= byte_n;
            last_q        <= last_n;
            have_q        <= have_n;
            abort_q       <= abort_n;
            tmo_q         <= tmo_n;
            req_grant     <= req_grant_n;
            tx_ready      <= tx_ready_n;
            rx_valid      <= rx_valid_n;
            rx_data       <= rx_data_n;
            done          <= done_n;
            err           <= err_n;
            busy          <= busy_n;
            spi_select    <= spi_select_n;
            mem_addr      <= mem_addr_n;
            write_n       <= write_n_n;
            read_n        <= read_n_n;
            data_from_cpu <= data_from_cpu_n;
        end
    end

    // Register access carried by each bus state.
    always_comb begin
        acc_en = 1'b1;
        acc    = '{addr: RXDATA, data: '0};
        case (state_q)
            ST_CLR_STAT: acc = '{addr: STATUS,  data: '0};
            ST_SET_SSEL: acc = '{addr: SSEL,    data: DATA_W'(ssel_q)};
            ST_SSO_ON:   acc = '{addr: CONTROL, data: CTRL_SSO};
            ST_WR_DATA:  acc = '{addr: TXDATA,  data: {8'h00, byte_q}};
            ST_RD_DATA:  acc = '{addr: RXDATA,  data: '0};
            ST_SSO_OFF:  acc = '{addr: CONTROL, data: '0};
            default:     acc_en = 1'b0;
        endcase
        acc_end = acc_en && (phase_q == PH_W'(2));
    end

    // Next state and next output values.
    always_comb begin
        state_n         = state_q;
        phase_n         = phase_q;
        owner_n         = owner_q;
        ssel_n          = ssel_q;
        byte_n          = byte_q;
        last_n          = last_q;
        have_n          = have_q;
        abort_n         = abort_q;
        tmo_n           = tmo_q;
        arb_update      = 1'b0;
        req_grant_n     = '0;
        tx_ready_n      = '0;
        rx_valid_n      = '0;
        rx_data_n       = rx_data;
        done_n          = '0;
        err_n           = '0;
        spi_select_n    = 1'b0;
        mem_addr_n      = '0;
        write_n_n       = 1'b1;
        read_n_n        = 1'b1;
        data_from_cpu_n = '0;

        // Phase 0 loads the bus, phase 1 holds it, phase 2 returns it idle.
        if (acc_en && !acc_end) begin
            spi_select_n    = 1'b1;
            mem_addr_n      = acc.addr;
            data_from_cpu_n = acc.data;
            write_n_n       = !reg_writable(acc.addr);
            read_n_n        = reg_writable(acc.addr);
            phase_n         = phase_q + PH_W'(1);
        end else if (acc_end) begin
            phase_n = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid != 2'b00) begin
                    arb_update  = 1'b1;
                    req_grant_n = grant_c;
                    owner_n     = grant_c[1];
                    ssel_n      = grant_c[1] ? req_ssel[NSLAVE +: NSLAVE] : req_ssel[0 +: NSLAVE];
                    abort_n     = 1'b0;
                    phase_n     = '0;
                    state_n     = ST_CLR_STAT;
                end
            end
            ST_CLR_STAT: if (acc_end) state_n = ST_SET_SSEL;
            ST_SET_SSEL: if (acc_end) state_n = ST_SSO_ON;
            ST_SSO_ON: begin
                if (acc_end) begin
                    have_n  = 1'b0;
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!have_q) begin
                    if (tx_valid[owner_q] && tx_ready[owner_q]) begin
                        byte_n = owner_q ? tx_data[15:8] : tx_data[7:0];
                        last_n = tx_last[owner_q];
                        have_n = 1'b1;
                    end
                end else if (readyfordata) begin
                    state_n = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                tmo_n = '0;
                if (acc_end) state_n = ST_WAIT_RX;
            end
            ST_WAIT_RX: begin
                // dataavailable takes priority over an expiring timeout.
                if (dataavailable) begin
                    state_n = ST_RD_DATA;
                end else if (tmo_q >= TMO_W'(TIMEOUT_CYC - 1)) begin
                    abort_n = 1'b1;
                    state_n = ST_SSO_OFF;
                end else begin
                    tmo_n = tmo_q + TMO_W'(1);
                end
            end
            ST_RD_DATA: begin
                if (acc_end) begin
                    rx_data_n           = data_to_cpu[7:0];
                    rx_valid_n[owner_q] = 1'b1;
                    if (last_q) begin
                        state_n = ST_SSO_OFF;
                    end else begin
                        have_n  = 1'b0;
                        state_n = ST_LOAD;
                    end
                end
            end
            ST_SSO_OFF: begin
                if (acc_end) begin
                    if (abort_q) err_n[owner_q]  = 1'b1;
                    else         done_n[owner_q] = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // tx_ready rises one cycle into LOAD so rx_valid of the previous byte comes first.
        if ((state_q == ST_LOAD) && (state_n == ST_LOAD) && !have_n) begin
            tx_ready_n[owner_q] = 1'b1;
        end
        busy_n = (state_n != ST_IDLE);
    end

endmodule
